// File: rtl/m_macfifo4.sv
// m_macfifo4: first-word-fall-through FIFO with valid/ready handshakes,
// a synchronous flush (CLR) and an asynchronous active-low reset that
// also zeroes storage, so OUT_Q reads 0 while the FIFO is held in reset.
module m_macfifo4 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4                 // power of two, 2..16
) (
    input  logic                     CLK,
    input  logic                     RESETL,
    input  logic                     CLR,
    input  logic                     IN_VALID,
    input  logic [WIDTH-1:0]         IN_D,
    output logic                     IN_READY,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         OUT_Q,
    output logic [$clog2(DEPTH):0]   COUNT
);
    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    L_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic             w_push;
    logic             w_pop;

    // Handshake flags come only from the occupancy register, so neither
    // ready nor valid has a combinational path from the other side.
    assign IN_READY  = (r_count != L_FULL);
    assign OUT_VALID = (r_count != '0);
    assign OUT_Q     = r_mem[r_rptr];
    assign COUNT     = r_count;

    // CLR suppresses both transfers; pointers and count are zeroed below.
    assign w_push = IN_VALID  & IN_READY  & ~CLR;
    assign w_pop  = OUT_VALID & OUT_READY & ~CLR;

    // Storage: written at the write pointer on push; cleared only by reset.
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= IN_D;
        end
    end

    // Pointers wrap naturally at DEPTH because they are exactly AW bits wide.
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (CLR) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
        end
    end

    // Occupancy: up on push only, down on pop only, held on both.
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            r_count <= '0;
        end else if (CLR) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - (AW+1)'(1);
        end
    end
endmodule

// File: tb/tb_m_macfifo4.sv
// Scoreboard bench for m_macfifo4: the driver keeps a queue-based reference
// FIFO and pushes each word it expects to be consumed into exp_q; a monitor
// on the falling edge pops exp_q whenever the DUT presents a consumed word.
module tb_m_macfifo4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RESETL;
    logic             CLR;
    logic             IN_VALID;
    logic [WIDTH-1:0] IN_D;
    logic             IN_READY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_Q;
    logic [2:0]       COUNT;

    m_macfifo4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESETL(RESETL), .CLR(CLR),
        .IN_VALID(IN_VALID), .IN_D(IN_D), .IN_READY(IN_READY),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_Q(OUT_Q),
        .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mdl [$];    // reference FIFO contents
    logic [WIDTH-1:0] exp_q [$];  // words expected to leave the DUT, in order
    int  pre_cnt = 0;             // model occupancy before the coming edge
    bit  mon_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and advance the reference model to the
    // state it will hold after the next rising edge.
    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit c);
        bit pu, po;
        @(posedge CLK);
        #1;
        IN_VALID = v; IN_D = d; OUT_READY = r; CLR = c;
        pre_cnt = mdl.size();
        pu = v && !c && (mdl.size() < DEPTH);
        po = r && !c && (mdl.size() > 0);
        if (c) mdl.delete();
        if (po) exp_q.push_back(mdl.pop_front());
        if (pu) mdl.push_back(d);
    endtask

    // Monitor: status vs model occupancy; consumed word vs scoreboard.
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("COUNT", 32'(COUNT), 32'(pre_cnt));
            chk("OUT_VALID", 32'(OUT_VALID), 32'(pre_cnt != 0));
            chk("IN_READY", 32'(IN_READY), 32'(pre_cnt != DEPTH));
            if (OUT_VALID && OUT_READY && !CLR) begin
                if (exp_q.size() == 0)
                    chk("unexpected_pop", 32'(OUT_Q), 32'hDEAD);
                else
                    chk("OUT_Q", 32'(OUT_Q), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_COUNT"}, 32'(COUNT), 0);
        chk({tag, "_OUT_VALID"}, 32'(OUT_VALID), 0);
        chk({tag, "_IN_READY"}, 32'(IN_READY), 1);
        chk({tag, "_OUT_Q"}, 32'(OUT_Q), 0);
    endtask

    initial begin
        // Reset held with a word offered: nothing may be accepted.
        RESETL = 1'b0; CLR = 1'b0; IN_VALID = 1'b1; IN_D = 8'hA5; OUT_READY = 1'b0;
        #2;  chk_reset_outputs("rst_async");
        #25; chk_reset_outputs("rst_held");
        #1;  RESETL = 1'b1; IN_VALID = 1'b0; mon_en = 1'b1;
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 1, 0);

        // Fill then drain.
        drive(1, 8'h11, 0, 0); drive(1, 8'h22, 0, 0);
        drive(1, 8'h33, 0, 0); drive(1, 8'h44, 0, 0);
        drive(1, 8'h99, 0, 0);              // full: must be refused
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0);

        // Full with simultaneous pop and offer: pop only, then accept.
        drive(1, 8'h11, 0, 0); drive(1, 8'h22, 0, 0);
        drive(1, 8'h33, 0, 0); drive(1, 8'h44, 0, 0);
        drive(1, 8'h55, 1, 0);
        drive(1, 8'h55, 0, 0);
        drive(0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0);

        // Streaming through the wrap point.
        for (int i = 1; i <= 10; i++) drive(1, 8'(i), 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 0, 0);

        // Flush with both handshakes active, then a fresh word.
        drive(1, 8'hC1, 0, 0); drive(1, 8'hC2, 0, 0); drive(1, 8'hC3, 0, 0);
        drive(1, 8'hEE, 1, 1);
        drive(1, 8'h77, 0, 0);
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 0, 0);

        // Asynchronous reset between edges with two words stored.
        drive(1, 8'hB1, 0, 0); drive(1, 8'hB2, 0, 0);
        drive(0, 8'h00, 0, 0);
        @(posedge CLK); #3;
        mon_en = 1'b0; RESETL = 1'b0;
        #1; chk_reset_outputs("rst_mid");
        mdl.delete(); exp_q.delete(); pre_cnt = 0;
        @(posedge CLK); #3;
        RESETL = 1'b1; mon_en = 1'b1;
        drive(1, 8'h3C, 0, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);

        for (int i = 0; i < DEPTH + 1; i++) drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 0, 0);
        @(negedge CLK); #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m_macfifo4.md
M_MACFIFO4 -- requirements
Module: m_macfifo4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 4, entry count, fixed at a power of two between 2 and 16.
REQ-003 Port CLK, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port RESETL, input, 1, reset, asynchronous and active-low.
REQ-005 Port CLR, input, 1, synchronous flush request.
REQ-006 Port IN_VALID, input, 1, upstream offers IN_D this cycle.
REQ-007 Port IN_D, input, WIDTH, write data.
REQ-008 Port IN_READY, output, 1, the FIFO accepts a word this cycle.
REQ-009 Port OUT_VALID, output, 1, OUT_Q holds the oldest stored word.
REQ-010 Port OUT_READY, input, 1, the downstream buffer stage consumes OUT_Q this cycle.
REQ-011 Port OUT_Q, output, WIDTH, head-of-queue data.
REQ-012 Port COUNT, output, log2(DEPTH)+1, current occupancy.

Function
REQ-013 A push SHALL occur on a rising CLK edge when IN_VALID=1, IN_READY=1 and CLR=0.
REQ-014 A pop SHALL occur on a rising CLK edge when OUT_VALID=1, OUT_READY=1 and CLR=0.
REQ-015 IN_READY SHALL equal (COUNT != DEPTH) and SHALL be driven from registered state only, with no combinational path from OUT_READY or IN_VALID.
REQ-016 OUT_VALID SHALL equal (COUNT != 0) and SHALL be driven from registered state only.
REQ-017 OUT_Q SHALL be the storage entry at the read pointer (first-word-fall-through), and SHALL be stable while OUT_VALID=1 and no pop occurs.
REQ-018 Latency: a word pushed at edge N SHALL appear at OUT_Q with OUT_VALID=1 after edge N when the FIFO was empty.
REQ-019 Write and read pointers SHALL be log2(DEPTH) bits, SHALL increment by one on push and pop respectively, and SHALL wrap from DEPTH-1 to 0.
REQ-020 COUNT SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 Simultaneous push and pop with 0<COUNT<DEPTH SHALL write the new word and advance both pointers with no data loss.
REQ-022 When full, a pop and an offered word on the same edge SHALL NOT push, because IN_READY=0; the offered word SHALL be accepted on the next cycle.
REQ-023 When empty, OUT_READY=1 SHALL have no effect.
REQ-024 IN_VALID while IN_READY=0 SHALL leave all state unchanged.
REQ-025 CLR=1 SHALL override push and pop and set both pointers and COUNT to 0 at the edge; storage contents need not be cleared.
REQ-026 Words SHALL emerge in strict push order with no duplication or loss.

Reset
REQ-027 RESETL=0 SHALL immediately, without waiting for CLK, force COUNT=0, both pointers=0, OUT_VALID=0, IN_READY=1, all storage entries=0, and OUT_Q=0.
REQ-028 RESETL asserted mid-transfer SHALL discard all stored words; the first edge after RESETL rises SHALL behave as an empty FIFO.

Verification
REQ-029 Reset: hold RESETL=0 with IN_VALID=1 and IN_D=0xA5 -> COUNT=0, OUT_VALID=0, IN_READY=1, OUT_Q=0x00; no push after release until an edge with IN_VALID=1.
REQ-030 Fill/drain: push 0x11,0x22,0x33,0x44 with OUT_READY=0 -> COUNT=4, IN_READY=0; then OUT_READY=1 -> OUT_Q=0x11,0x22,0x33,0x44 on successive cycles, then OUT_VALID=0.
REQ-031 Full plus simultaneous events: when full, IN_VALID=1 with IN_D=0x55 and OUT_READY=1 for one edge -> 0x11 popped, 0x55 not accepted, COUNT=3; next edge 0x55 accepted, COUNT=4.
REQ-032 Wrap-around: stream 10 words, 0x01..0x0A, with IN_VALID=OUT_READY=1 continuously -> output order 0x01..0x0A, COUNT never exceeds 1, pointers wrap twice.
REQ-033 Flush: with COUNT=3, assert CLR=1 together with IN_VALID=1 and OUT_READY=1 -> COUNT=0, OUT_VALID=0; the next pushed 0x77 is the next OUT_Q.
REQ-034 Asynchronous reset mid-stream: drop RESETL between edges with COUNT=2 -> outputs take reset values before the next edge, and the stale words never appear.
